// File: rtl/bcd_pkg.sv
// ---------------------------------------------------------------------------
// bcd_pkg
//   Shared types and helpers for the BCD decode path: the converter FSM
//   state encoding, the largest legal BCD digit, a nibble validity check and
//   a constant power-of-ten helper used for parameter sanity checks.
// ---------------------------------------------------------------------------
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } bcd_conv_state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // True when the nibble is a legal decimal digit (0..9).
  function automatic logic bcd_valid(input logic [3:0] nibble);
    return (nibble <= BCD_MAX);
  endfunction

  // 10**n, used at elaboration time to size-check the binary output.
  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 64'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage : bcd_pkg

// File: rtl/bcd_to_bin_seq_if.sv
// ---------------------------------------------------------------------------
// bcd_to_bin_seq_if
//   Handshake/data bundle between a controller and the BCD-to-binary
//   converter.
//     start   controller -> converter  request conversion of bcd_in
//     bcd_in  controller -> converter  packed BCD, MS digit in the top nibble
//     busy    converter -> controller  conversion in progress
//     done    converter -> controller  one-cycle pulse, bin_out/err valid
//     bin_out converter -> controller  binary result, held until next done
//     err     converter -> controller  some nibble was > 9
//   master = controller side, slave = converter side.
// ---------------------------------------------------------------------------
interface bcd_to_bin_seq_if #(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
);

  logic                  start;
  logic [4*DIGITS-1:0]   bcd_in;
  logic                  busy;
  logic                  done;
  logic [BIN_W-1:0]      bin_out;
  logic                  err;

  modport master (
    output start,
    output bcd_in,
    input  busy,
    input  done,
    input  bin_out,
    input  err
  );

  modport slave (
    input  start,
    input  bcd_in,
    output busy,
    output done,
    output bin_out,
    output err
  );

endinterface : bcd_to_bin_seq_if

// File: rtl/bcd_digit_mac.sv
// ---------------------------------------------------------------------------
// bcd_digit_mac
//   Combinational decimal multiply-accumulate step: acc_out = acc_in*10 + d,
//   computed as (acc_in<<3) + (acc_in<<1) + d, modulo 2**BIN_W.
//   An illegal digit (> 9) raises digit_err and contributes 0.
//   Ports:
//     acc_in    [BIN_W-1:0]  running binary accumulator
//     digit_in  [3:0]        next BCD digit
//     acc_out   [BIN_W-1:0]  updated accumulator
//     digit_err              digit_in was not a legal BCD digit
// ---------------------------------------------------------------------------
module bcd_digit_mac
  import bcd_pkg::*;
#(
  parameter int BIN_W = 7
) (
  input  logic [BIN_W-1:0] acc_in,
  input  logic [3:0]       digit_in,
  output logic [BIN_W-1:0] acc_out,
  output logic             digit_err
);

  logic [3:0] digit_eff;

  always_comb begin
    digit_err = !bcd_valid(digit_in);
    digit_eff = digit_err ? 4'd0 : digit_in;
    // Shift-add avoids a general multiplier; wraps naturally at BIN_W bits.
    acc_out   = (acc_in << 3) + (acc_in << 1) + BIN_W'(digit_eff);
  end

endmodule : bcd_digit_mac

// File: rtl/bcd_to_bin_seq.sv
// ---------------------------------------------------------------------------
// bcd_to_bin_seq
//   Sequential BCD-to-binary converter. On start (accepted only in IDLE) the
//   packed BCD word is latched and folded into a binary accumulator one
//   digit per clock, most significant digit first. The result and an
//   illegal-digit flag are registered on the edge entering DONE, where done
//   pulses for one cycle.
//   Ports:
//     clk    system clock
//     reset  synchronous, active-high reset
//     bus    bcd_to_bin_seq_if.slave: start, bcd_in in; busy, done,
//            bin_out, err out (all outputs registered or state-decoded)
// ---------------------------------------------------------------------------
module bcd_to_bin_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
) (
  input  logic                   clk,
  input  logic                   reset,
  bcd_to_bin_seq_if.slave        bus
);

  localparam int              SH_W    = 4 * DIGITS;
  localparam int              CNT_W   = $clog2(DIGITS) + 1;
  localparam longint unsigned MAX_VAL = pow10(DIGITS) - 64'd1;

  // Reject configurations whose output cannot hold 10**DIGITS-1.
  if (DIGITS < 1 || BIN_W < 4 || BIN_W > 62 || (64'd1 << BIN_W) <= MAX_VAL)
  begin : g_param_check
    $error("bcd_to_bin_seq: BIN_W=%0d too small for DIGITS=%0d", BIN_W, DIGITS);
  end

  bcd_conv_state_t    state_q,   state_d;
  logic [SH_W-1:0]    shift_q,   shift_d;
  logic [BIN_W-1:0]   acc_q,     acc_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic               err_acc_q, err_acc_d;
  logic [BIN_W-1:0]   bin_out_q, bin_out_d;
  logic               err_q,     err_d;

  logic [BIN_W-1:0]   mac_acc;
  logic               mac_err;

  bcd_digit_mac #(
    .BIN_W (BIN_W)
  ) u_mac (
    .acc_in    (acc_q),
    .digit_in  (shift_q[SH_W-1 -: 4]),
    .acc_out   (mac_acc),
    .digit_err (mac_err)
  );

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis infers latches.
    state_d   = state_q;
    shift_d   = shift_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    err_acc_d = err_acc_q;
    bin_out_d = bin_out_q;
    err_d     = err_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          shift_d   = bus.bcd_in;
          acc_d     = '0;
          cnt_d     = '0;
          err_acc_d = 1'b0;
          state_d   = CONV;
        end
      end

      CONV: begin
        acc_d     = mac_acc;
        err_acc_d = err_acc_q | mac_err;
        shift_d   = shift_q << 4;
        cnt_d     = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DIGITS - 1)) begin
          // Outputs update only here, so they stay stable outside DONE entry.
          bin_out_d = mac_acc;
          err_d     = err_acc_q | mac_err;
          state_d   = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples its _d value from before the edge, independent of order.
    if (reset) begin
      // NOTE: the datapath registers are cleared as well, not just the FSM,
      // because bin_out/err must read 0 after reset and an aborted
      // conversion must leave no residue behind.
      state_q   <= IDLE;
      shift_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      err_acc_q <= 1'b0;
      bin_out_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      err_acc_q <= err_acc_d;
      bin_out_q <= bin_out_d;
      err_q     <= err_d;
    end
  end

  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = (state_q == DONE);
  assign bus.bin_out = bin_out_q;
  assign bus.err     = err_q;

endmodule : bcd_to_bin_seq

// File: tb/tb_bcd_to_bin_seq.sv
// ---------------------------------------------------------------------------
// tb_bcd_to_bin_seq
//   Directed bench for bcd_to_bin_seq. Two instances share clk/reset:
//   a 2-digit/7-bit converter and a 4-digit/14-bit converter. Inputs change
//   1 time unit after posedge; outputs are sampled at that same point.
// ---------------------------------------------------------------------------
module tb_bcd_to_bin_seq;

  logic clk;
  logic reset;

  int vectors;
  int miscompares;

  bcd_to_bin_seq_if #(.DIGITS(2), .BIN_W(7))  bus2 ();
  bcd_to_bin_seq_if #(.DIGITS(4), .BIN_W(14)) bus4 ();

  bcd_to_bin_seq #(.DIGITS(2), .BIN_W(7)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  bcd_to_bin_seq #(.DIGITS(4), .BIN_W(14)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Checks all four outputs of the 2-digit instance.
  task automatic chk2(input string tag, input logic b, input logic d,
                      input logic [6:0] bin, input logic e);
    chk({tag, "_busy"}, 32'(bus2.busy), 32'(b));
    chk({tag, "_done"}, 32'(bus2.done), 32'(d));
    chk({tag, "_bin"},  32'(bus2.bin_out), 32'(bin));
    chk({tag, "_err"},  32'(bus2.err), 32'(e));
  endtask

  // Starts a 2-digit conversion and waits (bounded) for done.
  task automatic conv2(input string tag, input logic [7:0] bcd,
                       input logic [6:0] exp_bin, input logic exp_err);
    bus2.bcd_in = bcd;
    bus2.start  = 1'b1;
    tick();
    bus2.start  = 1'b0;
    for (int i = 0; i < 8 && !bus2.done; i++) tick();
    chk({tag, "_done"}, 32'(bus2.done), 32'd1);
    chk({tag, "_bin"},  32'(bus2.bin_out), 32'(exp_bin));
    chk({tag, "_err"},  32'(bus2.err), 32'(exp_err));
    tick();
  endtask

  initial begin
    logic [15:0] bcd4;
    int          exp4;
    int          dig;

    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    bus2.start  = 1'b0;
    bus2.bcd_in = '0;
    bus4.start  = 1'b0;
    bus4.bcd_in = '0;

    // Reset state
    tick();
    tick();
    chk2("rst", 1'b0, 1'b0, 7'd0, 1'b0);
    chk("rst4_busy", 32'(bus4.busy), 32'd0);
    chk("rst4_bin",  32'(bus4.bin_out), 32'd0);
    reset = 1'b0;
    tick();

    // 1. 8'h14 with cycle-accurate busy/done
    bus2.bcd_in = 8'h14;
    bus2.start  = 1'b1;           // cycle 0
    tick();                       // cycle 1
    bus2.start  = 1'b0;
    bus2.bcd_in = 8'h99;          // mid-conversion change must not matter
    chk2("t1_c1", 1'b1, 1'b0, 7'd0, 1'b0);
    tick();                       // cycle 2
    chk2("t1_c2", 1'b1, 1'b0, 7'd0, 1'b0);
    tick();                       // cycle 3
    chk2("t1_c3", 1'b1, 1'b1, 7'd14, 1'b0);
    tick();                       // cycle 4
    chk2("t1_c4", 1'b0, 1'b0, 7'd14, 1'b0);

    // 2. Plain values and hold between done pulses
    conv2("t2_05", 8'h05, 7'd5, 1'b0);
    conv2("t2_00", 8'h00, 7'd0, 1'b0);
    conv2("t2_99", 8'h99, 7'd99, 1'b0);
    tick();
    tick();
    chk2("t2_hold", 1'b0, 1'b0, 7'd99, 1'b0);

    // 3. Illegal nibble, then a clean conversion clears err
    conv2("t3_1A", 8'h1A, 7'd10, 1'b1);
    chk2("t3_hold", 1'b0, 1'b0, 7'd10, 1'b1);
    conv2("t3_07", 8'h07, 7'd7, 1'b0);

    // 4a. Start while busy is ignored
    bus2.bcd_in = 8'h12;
    bus2.start  = 1'b1;           // cycle 0
    tick();                       // cycle 1
    bus2.bcd_in = 8'h34;          // start still high, ignored
    tick();                       // cycle 2
    bus2.start  = 1'b0;
    tick();                       // cycle 3
    chk2("t4a_c3", 1'b1, 1'b1, 7'd12, 1'b0);
    for (int c = 4; c <= 6; c++) begin
      tick();
      chk2($sformatf("t4a_c%0d", c), 1'b0, 1'b0, 7'd12, 1'b0);
    end

    // 4b. Start held high: done every 4 cycles
    bus2.bcd_in = 8'h34;
    bus2.start  = 1'b1;           // cycle 0
    for (int c = 1; c <= 12; c++) begin
      tick();
      chk($sformatf("t4b_busy_c%0d", c), 32'(bus2.busy), 32'((c % 4) != 0));
      chk($sformatf("t4b_done_c%0d", c), 32'(bus2.done), 32'((c % 4) == 3));
      if (c >= 3) chk($sformatf("t4b_bin_c%0d", c), 32'(bus2.bin_out), 32'd34);
    end
    bus2.start = 1'b0;
    for (int i = 0; i < 4; i++) tick();

    // 5. Reset mid-conversion aborts with no done
    bus2.bcd_in = 8'h56;
    bus2.start  = 1'b1;           // cycle 0
    tick();                       // cycle 1
    bus2.start  = 1'b0;
    tick();                       // cycle 2
    reset = 1'b1;
    tick();                       // cycle 3
    reset = 1'b0;
    chk2("t5_c3", 1'b0, 1'b0, 7'd0, 1'b0);
    tick();                       // cycle 4
    chk2("t5_c4", 1'b0, 1'b0, 7'd0, 1'b0);
    conv2("t5_27", 8'h27, 7'd27, 1'b0);

    // 5b. Reset and start in the same cycle: reset wins
    bus2.bcd_in = 8'h88;
    bus2.start  = 1'b1;
    reset       = 1'b1;
    tick();
    reset       = 1'b0;
    bus2.start  = 1'b0;
    chk2("t5b", 1'b0, 1'b0, 7'd0, 1'b0);
    tick();
    chk2("t5b_after", 1'b0, 1'b0, 7'd0, 1'b0);

    // 6a. 4-digit maximum, done in cycle 5
    bus4.bcd_in = 16'h9999;
    bus4.start  = 1'b1;           // cycle 0
    tick();
    bus4.start  = 1'b0;
    for (int c = 2; c <= 5; c++) tick();
    chk("t6_c5_done", 32'(bus4.done), 32'd1);
    chk("t6_c5_bin",  32'(bus4.bin_out), 32'd9999);
    chk("t6_c5_err",  32'(bus4.err), 32'd0);
    tick();

    // 6b. Random legal BCD against a positional-weight model
    for (int n = 0; n < 1000; n++) begin
      bcd4 = '0;
      exp4 = 0;
      for (int k = 3; k >= 0; k--) begin
        dig  = int'($urandom_range(9));
        bcd4 = {bcd4[11:0], 4'(dig)};
        exp4 = exp4 + dig * ((k == 3) ? 1000 : (k == 2) ? 100 : (k == 1) ? 10 : 1);
      end
      bus4.bcd_in = bcd4;
      bus4.start  = 1'b1;
      tick();
      bus4.start  = 1'b0;
      for (int i = 0; i < 10 && !bus4.done; i++) tick();
      chk($sformatf("t6_rnd%0d_done", n), 32'(bus4.done), 32'd1);
      chk($sformatf("t6_rnd%0d_bin_%04h", n, bcd4), 32'(bus4.bin_out), 32'(exp4));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_bcd_to_bin_seq
